// File: rtl/key_input_pkg.sv
// Shared types and defaults for the player-input front end: debounce FSM
// states, difficulty codes, score width and auto-difficulty thresholds.
package key_input_pkg;

    // Debounce FSM states; the encoding doubles as the accepted button level.
    typedef enum logic {
        STABLE_LO = 1'b0,
        STABLE_HI = 1'b1
    } deb_state_t;

    // Difficulty codes, 0 = easiest.
    typedef enum logic [1:0] {
        EASY_0 = 2'd0,
        EASY_1 = 2'd1,
        EASY_2 = 2'd2,
        EASY_3 = 2'd3
    } easy_t;

    // Width of the score fed back from the control stage.
    localparam int SCORE_W = 10;

    // Default auto-difficulty thresholds.
    localparam int DEF_LVL1_SCORE = 5;
    localparam int DEF_LVL2_SCORE = 10;
    localparam int DEF_LVL3_SCORE = 15;

    // Unsigned threshold mapping from score to difficulty code, no hysteresis.
    function automatic easy_t score_to_easy(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] lvl1,
        input logic [SCORE_W-1:0] lvl2,
        input logic [SCORE_W-1:0] lvl3
    );
        easy_t code;
        if (score >= lvl3) begin
            code = EASY_3;
        end else if (score >= lvl2) begin
            code = EASY_2;
        end else if (score >= lvl1) begin
            code = EASY_1;
        end else begin
            code = EASY_0;
        end
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: synchroniser chain, two-state debounce FSM with a stability
// counter, and a registered one-cycle pulse on each accepted rising level.
module btn_debounce
    import key_input_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int              CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    deb_state_t             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   rise_q;
    logic                   synced;

    // Oldest synchroniser stage is the only copy of the button the FSM sees.
    assign synced = sync_q[SYNC_STAGES-1];

    // Synchronise the raw button, then accept a new level only after it has
    // been seen unchanged for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block and
        // the sensitivity list carries the clock only.
        if (!reset) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every stage read the value
            // its predecessor held before this edge, giving a true shift.
            sync_q[0] <= btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            rise_q <= 1'b0;
            unique case (state_q)
                STABLE_LO: begin
                    if (synced) begin
                        if (cnt_q == DEB_LAST) begin
                            state_q <= STABLE_HI;
                            cnt_q   <= '0;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                STABLE_HI: begin
                    if (!synced) begin
                        if (cnt_q == DEB_LAST) begin
                            state_q <= STABLE_LO;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level = (state_q == STABLE_HI);
    assign rise  = rise_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Player-input front end: debounced up/down buttons become rate-limited step
// pulses, the pause button toggles a pause level, and the difficulty code is
// taken from switches or derived from the fed-back score.
module key_input_ctrl
    import key_input_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DEB_CYCLES    = 1_000_000,
    parameter int REPEAT_CYCLES = 200_000,
    parameter int LVL1_SCORE    = DEF_LVL1_SCORE,
    parameter int LVL2_SCORE    = DEF_LVL2_SCORE,
    parameter int LVL3_SCORE    = DEF_LVL3_SCORE
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_pause,
    input  logic               sw_auto,
    input  logic [1:0]         sw_easy,
    input  logic [SCORE_W-1:0] score,
    output logic               up_key_press,
    output logic               down_key_press,
    output logic               pause,
    output logic [1:0]         easy
);

    localparam int               RPT_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    localparam logic [SCORE_W-1:0] LVL1 = SCORE_W'(LVL1_SCORE);
    localparam logic [SCORE_W-1:0] LVL2 = SCORE_W'(LVL2_SCORE);
    localparam logic [SCORE_W-1:0] LVL3 = SCORE_W'(LVL3_SCORE);

    logic up_lvl, up_rise;
    logic down_lvl, down_rise;
    logic pause_lvl, pause_rise;

    btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_up (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_up),
        .level(up_lvl),
        .rise (up_rise)
    );

    btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_down (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_down),
        .level(down_lvl),
        .rise (down_rise)
    );

    btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_pause (
        .clk  (clk),
        .reset(reset),
        .btn  (btn_pause),
        .level(pause_lvl),
        .rise (pause_rise)
    );

    // Channel 0 is up, channel 1 is down; each sees the other's level so the
    // pair can lock each other out while both are held.
    logic [1:0] step_lvl;
    logic [1:0] step_rise;
    logic [1:0] step_pulse;

    assign step_lvl  = {down_lvl, up_lvl};
    assign step_rise = {down_rise, up_rise};

    for (genvar ch = 0; ch < 2; ch++) begin : g_step
        logic [RPT_W-1:0] cnt_q;
        logic             pulse_q;
        logic             blocked_q;
        logic             other_lvl;

        assign other_lvl = step_lvl[1-ch];

        // Auto-repeat: pulse on a fresh press (or when the opposing button is
        // let go), then again every REPEAT_CYCLES while held alone.
        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt_q     <= '0;
                pulse_q   <= 1'b0;
                blocked_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                if (!step_lvl[ch]) begin
                    cnt_q     <= '0;
                    blocked_q <= 1'b0;
                end else if (other_lvl) begin
                    cnt_q     <= RPT_LAST;
                    blocked_q <= 1'b1;
                end else if (step_rise[ch] || blocked_q || (cnt_q == '0)) begin
                    pulse_q   <= 1'b1;
                    cnt_q     <= RPT_LAST;
                    blocked_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - RPT_W'(1);
                end
            end
        end

        assign step_pulse[ch] = pulse_q;
    end

    assign up_key_press   = step_pulse[0];
    assign down_key_press = step_pulse[1];

    logic pause_q;

    // Pause flips once per accepted press; release and long holds do nothing.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pause_q <= 1'b0;
        end else if (pause_rise) begin
            pause_q <= ~pause_q;
        end
    end

    assign pause = pause_q;

    easy_t easy_q;

    // Difficulty follows the score thresholds in auto mode, else the switches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            easy_q <= EASY_0;
        end else if (sw_auto) begin
            easy_q <= score_to_easy(score, LVL1, LVL2, LVL3);
        end else begin
            easy_q <= easy_t'(sw_easy);
        end
    end

    assign easy = easy_q;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl with short debounce and repeat periods.
module tb_key_input_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_pause;
    logic       sw_auto;
    logic [1:0] sw_easy;
    logic [9:0] score;
    logic       up_key_press;
    logic       down_key_press;
    logic       pause;
    logic [1:0] easy;

    int passed;
    int total;

    key_input_ctrl #(
        .SYNC_STAGES  (2),
        .DEB_CYCLES   (4),
        .REPEAT_CYCLES(8),
        .LVL1_SCORE   (5),
        .LVL2_SCORE   (10),
        .LVL3_SCORE   (15)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_pause     (btn_pause),
        .sw_auto       (sw_auto),
        .sw_easy       (sw_easy),
        .score         (score),
        .up_key_press  (up_key_press),
        .down_key_press(down_key_press),
        .pause         (pause),
        .easy          (easy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    int n_a, n_b, first_a, second_a, last_a, first_b, second_b, idx;
    logic seen, prev;
    int scores [8] = '{0, 4, 5, 9, 10, 15, 1023, 0};
    int easys  [8] = '{0, 0, 1, 1, 2, 3, 3, 0};
    int pause_exp [3] = '{1, 0, 1};
    int prev_easy;

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b0;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_pause = 1'b0;
        sw_auto   = 1'b1;
        sw_easy   = 2'd3;
        score     = 10'd20;

        // Reset holds everything at zero even with auto mode and a high score.
        repeat (3) tick();
        check("reset_up", up_key_press, 0);
        check("reset_down", down_key_press, 0);
        check("reset_pause", pause, 0);
        check("reset_easy", easy, 0);
        reset   = 1'b1;
        sw_auto = 1'b0;
        sw_easy = 2'd0;
        score   = 10'd0;
        repeat (2) tick();
        check("idle_easy", easy, 0);

        // Clean up press held 30 cycles.
        btn_up = 1'b1;
        n_a = 0; n_b = 0; first_a = -1; second_a = -1; last_a = -1;
        for (int t = 1; t <= 60; t++) begin
            if (t == 31) btn_up = 1'b0;
            tick();
            if (up_key_press) begin
                n_a++;
                if (first_a < 0) first_a = t;
                else if (second_a < 0) second_a = t;
                last_a = t;
            end
            if (down_key_press) n_b++;
        end
        check("hold_first_pulse_edge", first_a, 7);
        check("hold_second_pulse_edge", second_a, 15);
        check("hold_last_pulse_edge", last_a, 31);
        check("hold_pulse_count", n_a, 4);
        check("hold_no_down", n_b, 0);

        // Bouncy up: toggles every 2 cycles, never stable long enough.
        n_a = 0; seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            btn_up = ((t / 2) % 2) == 0;
            tick();
            if (up_key_press) n_a++;
            if (dut.up_lvl) seen = 1'b1;
        end
        btn_up = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (up_key_press) n_a++;
            if (dut.up_lvl) seen = 1'b1;
        end
        check("bounce_pulses", n_a, 0);
        check("bounce_level_high", seen, 0);

        // Up and down held together, then up released.
        btn_up = 1'b1; btn_down = 1'b1;
        n_a = 0; n_b = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (up_key_press) n_a++;
            if (down_key_press) n_b++;
        end
        check("both_up_pulses", n_a, 0);
        check("both_down_pulses", n_b, 0);
        check("both_levels_high", {dut.up_lvl, dut.down_lvl}, 2'b11);
        btn_up = 1'b0;
        n_a = 0; n_b = 0; idx = -1; first_b = -1; second_b = -1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (!dut.up_lvl && idx < 0) idx = t;
            if (up_key_press) n_a++;
            if (down_key_press) begin
                n_b++;
                if (first_b < 0) first_b = t;
                else if (second_b < 0) second_b = t;
            end
        end
        check("release_up_fall_edge", idx, 6);
        check("release_down_first", first_b, 7);
        check("release_down_second", second_b, 15);
        check("release_down_count", n_b, 3);
        check("release_up_pulses", n_a, 0);
        btn_down = 1'b0;
        repeat (20) tick();

        // Three clean pause presses.
        for (int p = 0; p < 3; p++) begin
            btn_pause = 1'b1;
            prev = pause; n_a = 0; first_a = -1; idx = -1;
            for (int t = 1; t <= 20; t++) begin
                if (t == 11) btn_pause = 1'b0;
                tick();
                if (dut.pause_rise && idx < 0) idx = t;
                if (pause !== prev) begin
                    n_a++;
                    if (first_a < 0) first_a = t;
                    prev = pause;
                end
            end
            check($sformatf("pause%0d_rise_edge", p), idx, 6);
            check($sformatf("pause%0d_toggle_edge", p), first_a, 7);
            check($sformatf("pause%0d_toggle_count", p), n_a, 1);
            check($sformatf("pause%0d_level", p), pause, pause_exp[p]);
        end

        // Auto difficulty from score, then manual override.
        sw_auto = 1'b1;
        prev_easy = 0;
        for (int i = 0; i < 8; i++) begin
            score = 10'(scores[i]);
            #1;
            check($sformatf("easy_hold_score%0d", scores[i]), easy, prev_easy);
            tick();
            check($sformatf("easy_score%0d", scores[i]), easy, easys[i]);
            prev_easy = easys[i];
        end
        sw_auto = 1'b0;
        sw_easy = 2'd2;
        #1;
        check("easy_manual_hold", easy, 0);
        tick();
        check("easy_manual", easy, 2);

        // Down held across a one-cycle reset pulse.
        btn_down = 1'b1;
        repeat (10) tick();
        reset = 1'b0;
        tick();
        check("midreset_up", up_key_press, 0);
        check("midreset_down", down_key_press, 0);
        check("midreset_pause", pause, 0);
        check("midreset_easy", easy, 0);
        reset = 1'b1;
        n_b = 0; first_b = -1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (down_key_press) begin
                n_b++;
                if (first_b < 0) first_b = t;
            end
        end
        check("after_reset_first_down", first_b, 7);
        check("after_reset_down_count", n_b, 2);
        btn_down = 1'b0;
        repeat (10) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
